// File: rtl/atomic_counter_bank.sv
// Bank of NUM_CH event counters with multi-beat atomic snapshot reads over a BUS_W bus.
// Define ATOMIC_CNT_SAT_EN to make counters saturate at all-ones instead of wrapping.
module atomic_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64,
  parameter int BUS_W  = 32,
  localparam int BEATS  = CNT_W / BUS_W,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig_i,
  input  logic              req_i,
  input  logic              atomic_i,
  input  logic [SEL_W-1:0]  ch_sel_i,
  input  logic              clr_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [BUS_W-1:0]  count_o
);

  if ((CNT_W % BUS_W) != 0 || BEATS < 2 || NUM_CH < 1) begin : g_bad_cfg
    $error("atomic_counter_bank: CNT_W must be a multiple of BUS_W giving at least two beats");
  end

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0]             snap_r;
  logic [BEAT_W-1:0]            beat_r;
  state_t                       state_r;

  logic             atomic_req_s;
  logic [CNT_W-1:0] sel_cnt_s;
  logic             sel_hit_s;

  assign atomic_req_s = req_i & atomic_i;

  // Select the addressed channel; an out-of-range select yields zero and no hit.
  always_comb begin
    sel_cnt_s = '0;
    sel_hit_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_hit_s = sel_hit_s | (ch_sel_i == SEL_W'(c));
      sel_cnt_s = sel_cnt_s | ({CNT_W{ch_sel_i == SEL_W'(c)}} & cnt_r[c]);
    end
  end

  // Event counters; a clear-on-read reloads the same-cycle trigger so no event is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (atomic_req_s && clr_i && (ch_sel_i == SEL_W'(c))) begin
          cnt_r[c] <= CNT_W'(trig_i[c]);
        end else if (trig_i[c]) begin
`ifdef ATOMIC_CNT_SAT_EN
          if (cnt_r[c] != {CNT_W{1'b1}}) begin
            cnt_r[c] <= cnt_r[c] + CNT_W'(1);
          end else begin
            cnt_r[c] <= cnt_r[c];
          end
`else
          cnt_r[c] <= cnt_r[c] + CNT_W'(1);
`endif
        end else begin
          cnt_r[c] <= cnt_r[c];
        end
      end
    end
  end

  // Read FSM: an atomic beat snapshots and answers beat 0, later beats replay the snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      beat_r  <= '0;
      snap_r  <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      count_o <= '0;
    end else if (atomic_req_s) begin
      state_r <= BURST;
      beat_r  <= BEAT_W'(1);
      snap_r  <= sel_cnt_s;
      ack_o   <= 1'b1;
      err_o   <= ~sel_hit_s;
      count_o <= sel_cnt_s[BUS_W-1:0];
    end else if (req_i && (state_r == BURST)) begin
      ack_o   <= 1'b1;
      err_o   <= 1'b0;
      count_o <= snap_r[int'(beat_r) * BUS_W +: BUS_W];
      if (beat_r == LAST_BEAT) begin
        state_r <= IDLE;
        beat_r  <= '0;
      end else begin
        state_r <= BURST;
        beat_r  <= beat_r + BEAT_W'(1);
      end
    end else if (req_i) begin
      // Non-atomic beat with no read in flight.
      ack_o   <= 1'b1;
      err_o   <= 1'b1;
      count_o <= '0;
    end else begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      count_o <= '0;
    end
  end

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Directed table-driven bench for atomic_counter_bank (NUM_CH=4, CNT_W=64, BUS_W=32).
module tb_atomic_counter_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  trig_i;
  logic        req_i;
  logic        atomic_i;
  logic [1:0]  ch_sel_i;
  logic        clr_i;
  logic        ack_o;
  logic        err_o;
  logic [31:0] count_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  atomic_counter_bank #(.NUM_CH(4), .CNT_W(64), .BUS_W(32)) dut (
    .clk(clk), .reset(reset), .trig_i(trig_i), .req_i(req_i), .atomic_i(atomic_i),
    .ch_sel_i(ch_sel_i), .clr_i(clr_i), .ack_o(ack_o), .err_o(err_o), .count_o(count_o)
  );

  typedef struct {
    logic        req;
    logic        atomic;
    logic [1:0]  sel;
    logic        clr;
    logic [3:0]  trig;
    logic        ack;
    logic        err;
    logic [31:0] count;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic ea, input logic ee, input logic [31:0] ec);
    tests++;
    if (ack_o !== ea || err_o !== ee || count_o !== ec) begin
      fails++;
      $display("FAIL %s: got ack=%0b err=%0b count=%h, expected ack=%0b err=%0b count=%h",
               name, ack_o, err_o, count_o, ea, ee, ec);
    end
  endtask

  // Drive one cycle of inputs and return at the following falling edge.
  task automatic step(input logic rq, input logic at, input logic [1:0] sel,
                      input logic cl, input logic [3:0] tg);
    req_i = rq; atomic_i = at; ch_sel_i = sel; clr_i = cl; trig_i = tg;
    @(negedge clk);
  endtask

  initial begin
    // Counters start at 0 after reset; comments show counter state after each row.
    vt[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b1001, 1'b0, 1'b0, 32'h0};  // c0=1 c3=1
    vt[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b1001, 1'b0, 1'b0, 32'h0};  // c0=2 c3=2
    vt[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b1001, 1'b0, 1'b0, 32'h0};  // c0=3 c3=3
    vt[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0};  // N in IDLE
    vt[4]  = '{1'b1, 1'b1, 2'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h3};  // snap 3, c0=4
    vt[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h0};  // c0=5
    vt[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0};  // third beat
    vt[7]  = '{1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0, 32'h3};  // clr c3 -> 1
    vt[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h1};
    vt[10] = '{1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h5};  // restart in BURST
    vt[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0};
    vt[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0};
    vt[13] = '{1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h5};  // A N A N
    vt[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0};
    vt[15] = '{1'b1, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h1};
    vt[16] = '{1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0};
    vt[17] = '{1'b1, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b1, 1'b0, 32'h0};

    reset = 1'b0; req_i = 1'b0; atomic_i = 1'b0; ch_sel_i = 2'd0; clr_i = 1'b0; trig_i = 4'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 1'b0, 1'b0, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vt[i].req, vt[i].atomic, vt[i].sel, vt[i].clr, vt[i].trig);
      check($sformatf("vec%0d", i), vt[i].ack, vt[i].err, vt[i].count);
    end

    // Preload: c3=0, c2=0xFFFF_FFFF, c1=5, c0=all-ones.
    force dut.cnt_r = {64'h0, 64'h0000_0000_FFFF_FFFF, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF};
    #1;
    release dut.cnt_r;

    step(1'b1, 1'b1, 2'd2, 1'b0, 4'b0100); check("carry_lo", 1'b1, 1'b0, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0100); check("carry_hi", 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 2'd2, 1'b0, 4'b0000); check("carry_live_lo", 1'b1, 1'b0, 32'h1);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("carry_live_hi", 1'b1, 1'b0, 32'h1);

    step(1'b1, 1'b1, 2'd1, 1'b1, 4'b0010); check("clr_lo", 1'b1, 1'b0, 32'h5);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("clr_hi", 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 2'd1, 1'b0, 4'b0000); check("clr_next_lo", 1'b1, 1'b0, 32'h1);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("clr_next_hi", 1'b1, 1'b0, 32'h0);

    step(1'b0, 1'b0, 2'd0, 1'b0, 4'b0001); check("top_trig_idle", 1'b0, 1'b0, 32'h0);
`ifdef ATOMIC_CNT_SAT_EN
    step(1'b1, 1'b1, 2'd0, 1'b0, 4'b0000); check("top_lo", 1'b1, 1'b0, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("top_hi", 1'b1, 1'b0, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 2'd0, 1'b1, 4'b0001); check("top_clr_lo", 1'b1, 1'b0, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("top_clr_hi", 1'b1, 1'b0, 32'hFFFF_FFFF);
`else
    step(1'b1, 1'b1, 2'd0, 1'b0, 4'b0000); check("top_lo", 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("top_hi", 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 2'd0, 1'b1, 4'b0001); check("top_clr_lo", 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("top_clr_hi", 1'b1, 1'b0, 32'h0);
`endif
    step(1'b1, 1'b1, 2'd0, 1'b0, 4'b0000); check("top_reload", 1'b1, 1'b0, 32'h1);
    step(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000); check("top_quiet", 1'b0, 1'b0, 32'h0);

    // Mid-burst reset: beat 0 of ch1, then a request during reset gets no ack.
    step(1'b1, 1'b1, 2'd1, 1'b0, 4'b0000); check("rst_beat0", 1'b1, 1'b0, 32'h1);
    reset = 1'b0;
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("rst_cycle", 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("rst_then_n", 1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b1, 2'd1, 1'b0, 4'b0000); check("rst_cleared_lo", 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 4'b0000); check("rst_cleared_hi", 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/atomic_counter_bank.md
# atomic_counter_bank

- Bank of `NUM_CH` independent event counters, each `CNT_W` bits wide, read over a `BUS_W`-bit request/acknowledge bus.
- A multi-beat read returns a single-copy-atomic snapshot of one channel: every beat of a read reflects the same instant.
- The bank can optionally clear the channel as part of the read, without losing events.
- Successor to the 64-bit/32-bit single-channel event counter; sits between the SoC event sources and the microcontroller bus.

## Interface
Parameters:
- `NUM_CH`, 4, number of counter channels; ≥1.
- `CNT_W`, 64, counter width; must be an integer multiple of `BUS_W`.
- `BUS_W`, 32, read bus width. `BEATS = CNT_W/BUS_W` must be ≥2.

Ports:
- `clk`  in  1  single clock; all flops rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `trig_i`  in  NUM_CH  per-channel increment strobe; one increment per cycle high.
- `req_i`  in  1  read request; may be a single pulse or back-to-back.
- `atomic_i`  in  1  marks the first beat of a read and triggers the snapshot.
- `ch_sel_i`  in  max(1,$clog2(NUM_CH))  channel to snapshot; sampled only on atomic beats.
- `clr_i`  in  1  clear-on-read; sampled only on atomic beats.
- `ack_o`  out  1  acknowledge, one per request.
- `err_o`  out  1  protocol error flag, valid with `ack_o`.
- `count_o`  out  BUS_W  read data, valid with `ack_o`.

## Operation
- Counters:
  - `cnt[c]` increments by 1 in every cycle `trig_i[c]`=1.
  - On reaching all-ones, the counter wraps to 0 (see Configuration).
- FSM states IDLE and BURST, with a beat index `beat` of width $clog2(BEATS).
- Atomic request (`req_i`=1 and `atomic_i`=1), accepted in any state:
  - `snap <= cnt[ch_sel_i]`, the pre-increment value in that cycle.
  - The channel is latched. `beat <= 1`, state goes to BURST.
  - The response is `snap[BUS_W-1:0]` with `err_o`=0.
  - An atomic request during BURST abandons the current read and restarts with a fresh snapshot.
- Non-atomic request (`req_i`=1, `atomic_i`=0) in BURST:
  - Response is `snap[beat*BUS_W +: BUS_W]`, `err_o`=0, then `beat++`.
  - After the beat with index `BEATS-1`, state returns to IDLE.
- Non-atomic request in IDLE:
  - Response is `count_o`=0 with `err_o`=1.
  - State does not change and no snapshot is taken.
- Clear-on-read (atomic request with `clr_i`=1, `ch_sel_i`=c):
  - The snapshot takes the old value of `cnt[c]`.
  - `cnt[c]` becomes `trig_i[c]` (0 or 1), so a same-cycle event is counted in the new epoch.
- `ch_sel_i` ≥ `NUM_CH`: the snapshot is 0, `err_o`=1 on beat 0, no clear occurs, and the read still proceeds through BURST.
- Cycles with `req_i`=0 do not change state. BURST waits indefinitely for the next beat.
- `ch_sel_i` and `clr_i` are ignored on non-atomic beats.

## Timing
- Reset (`reset`=0 sampled at a rising edge) applies to everything:
  - All `cnt` are cleared, `snap`=0, state=IDLE, `beat`=0.
  - `ack_o`=0, `err_o`=0, `count_o`=0.
  - Reset mid-burst abandons the read; no ack is issued for a request in the reset cycle.
- Fixed latency of 1:
  - A request sampled at edge T produces `ack_o`=1 with `count_o`/`err_o` valid after edge T, for exactly one cycle per request.
  - N back-to-back requests produce N consecutive ack cycles.
- When `ack_o`=0, `count_o`=0 and `err_o`=0 (registered; outputs do not hold their previous value).
- All outputs are registered; there is no combinational path from inputs to outputs.
- `trig_i` increments continue during BURST. They never affect the words of the read in flight.

## Configuration
- `ATOMIC_CNT_SAT_EN` defined:
  - Each counter saturates at all-ones; further triggers are dropped until a clear-on-read or reset.
  - A clear-on-read of a saturated counter loads `trig_i[c]`.
- Undefined: counters wrap modulo 2^CNT_W.

## Test plan
Parameters for all scenarios: `NUM_CH`=4, `CNT_W`=64, `BUS_W`=32.

- **Carry across the word boundary.**
  - Stimulus: ch2 at 0x0000_0000_FFFF_FFFF, atomic read of ch2 with `trig_i[2]` high every cycle.
  - Required: beats return 0xFFFF_FFFF then 0x0000_0000; the live counter ends at ≥0x1_0000_0001.
- **Clear-on-read with a same-cycle trigger.**
  - Stimulus: atomic read of ch1 = 0x5 with `clr_i`=1 and `trig_i[1]`=1 in the same cycle.
  - Required: beats return 0x5 then 0x0; the next read of ch1 returns 0x1 / 0x0.
- **Protocol errors.**
  - Non-atomic request in IDLE → ack, `err_o`=1, `count_o`=0.
  - Atomic request in BURST → new snapshot, beat 0 data.
  - Third non-atomic beat → `err_o`=1.
- **Back-to-back reads.**
  - Stimulus: 4 consecutive requests (A, N, A, N) on ch0 then ch3.
  - Required: 4 consecutive acks with the correct words, one-cycle latency each.
- **Mid-burst reset.**
  - Stimulus: `reset`=0 after beat 0.
  - Required: all outputs 0, no ack for that cycle, then a non-atomic request gives `err_o`=1.
- **Wrap vs saturate at all-ones.**
  - Stimulus: ch0 at 0xFFFF_FFFF_FFFF_FFFF, one trigger, then read ch0.
  - Without `ATOMIC_CNT_SAT_EN`: read returns 0 / 0.
  - With `ATOMIC_CNT_SAT_EN`: read returns 0xFFFF_FFFF / 0xFFFF_FFFF.
